instr_split_queue: RTL and testbench

- Parametrised successor to the combinational instruction-field splitter.
- Buffers fetched MIPS instructions with their PCs in a DEPTH-entry FIFO.
- Presents the head entry already split into fields, plus derived immediates and jump target.
- Sits between fetch and decode in the pipelined CPU. Uses valid/ready handshakes on both sides and supports a synchronous flush for branch redirect.

---
 rtl/instr_split_queue.sv | 162 ++++++++++++++++
 tb/tb_instr_split_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_split_queue.sv
// instr_split_queue: DEPTH-entry fetch->decode FIFO that presents its head
//   instruction pre-split into MIPS fields, immediates and jump target.
// Latency: an accepted push is visible at the head on the following cycle.
// Backpressure: in_ready depends only on occupancy, never on out_ready.
//
// Ports:
//   clk, reset_n   - rising-edge clock, synchronous active-low reset
//   flush          - drops every buffered entry (branch redirect)
//   in_valid/in_ready/in_instr/in_pc   - fetch side handshake and payload
//   out_valid/out_ready/out_pc         - decode side handshake and head PC
//   op, rs, rt, rd, shamt, func, immediate, instr_index - head instr fields
//   imm_sext, imm_zext, imm_lui        - derived 32-bit immediates
//   jump_target                        - J-type target built from head PC+4
//   count                              - current occupancy
// All field and derived outputs read 0 while out_valid is low.

module instr_split_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PC_W-1:0]    in_pc,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,

  output logic [5:0]         op,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         func,
  output logic [15:0]        immediate,
  output logic [31:0]        imm_sext,
  output logic [31:0]        imm_zext,
  output logic [31:0]        imm_lui,
  output logic [25:0]        instr_index,
  output logic [PC_W-1:0]    jump_target,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Bits of the PC that the J-type target replaces; everything above is
  // inherited from PC+4 (the 256 MB region of the delay slot).
  localparam logic [PC_W-1:0] REGION_LOW_MASK = PC_W'(32'h0FFF_FFFF);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Payload storage is deliberately left unreset; out_valid gates it.
  logic [31:0]      instr_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q    [DEPTH];

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  logic push;
  logic pop;
  logic mem_wr_en;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;

  // A flush discards the same-cycle push, so the slot is not written either.
  assign mem_wr_en = push && !flush;

  // ---------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  // ---------------------------------------------------------------------
  // Head decode (purely from registered storage)
  // ---------------------------------------------------------------------
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] jt_raw;

  // Gate at the source so every slice below is zero when the queue is empty.
  assign head_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign head_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

  assign out_pc      = head_pc;
  assign op          = head_instr[31:26];
  assign rs          = head_instr[25:21];
  assign rt          = head_instr[20:16];
  assign rd          = head_instr[15:11];
  assign shamt       = head_instr[10:6];
  assign func        = head_instr[5:0];
  assign immediate   = head_instr[15:0];
  assign instr_index = head_instr[25:0];

  assign imm_sext = {{16{head_instr[15]}}, head_instr[15:0]};
  assign imm_zext = {16'h0, head_instr[15:0]};
  assign imm_lui  = {head_instr[15:0], 16'h0};

  // PC+4 wraps modulo 2^PC_W; the mask form also works when PC_W == 28.
  assign pc_plus4    = head_pc + PC_W'(4);
  assign jt_raw      = (pc_plus4 & ~REGION_LOW_MASK) | PC_W'({head_instr[25:0], 2'b00});
  assign jump_target = out_valid ? jt_raw : '0;

  assign count = count_q;

endmodule

// File: tb/tb_instr_split_queue.sv
module tb_instr_split_queue;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [5:0]       op;
  logic [4:0]       rs, rt, rd, shamt;
  logic [5:0]       func;
  logic [15:0]      immediate;
  logic [31:0]      imm_sext, imm_zext, imm_lui;
  logic [25:0]      instr_index;
  logic [PC_W-1:0]  jump_target;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  instr_split_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .immediate(immediate), .imm_sext(imm_sext), .imm_zext(imm_zext),
    .imm_lui(imm_lui), .instr_index(instr_index), .jump_target(jump_target),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] wrap_instr(input int i);
    return 32'h2400_0000 | 32'(i);
  endfunction

  function automatic logic [PC_W-1:0] wrap_pc(input int i);
    return PC_W'(32'h1000 + 4 * i);
  endfunction

  initial begin
    logic [31:0] q_instr [$];
    logic [31:0] q_pc    [$];
    int          k;
    logic        m_push, m_pop;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = '0;
    out_ready = 1'b0;

    // ---- Reset then idle ----
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_count",    64'(count),       64'd0);
    chk("rst_in_ready", 64'(in_ready),    64'd1);
    chk("rst_out_vld",  64'(out_valid),   64'd0);
    chk("rst_op",       64'(op),          64'd0);
    chk("rst_out_pc",   64'(out_pc),      64'd0);
    chk("rst_sext",     64'(imm_sext),    64'd0);
    chk("rst_jt",       64'(jump_target), 64'd0);

    // ---- Pop request while empty is ignored ----
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_pop_count", 64'(count), 64'd0);

    // ---- Single lw push ----
    push1(32'h8D09FFFC, 32'h0000_3000);
    chk("lw_out_vld", 64'(out_valid), 64'd1);
    chk("lw_count",   64'(count),     64'd1);
    chk("lw_out_pc",  64'(out_pc),    64'h3000);
    chk("lw_op",      64'(op),        64'h23);
    chk("lw_rs",      64'(rs),        64'd8);
    chk("lw_rt",      64'(rt),        64'd9);
    chk("lw_imm",     64'(immediate), 64'hFFFC);
    chk("lw_sext",    64'(imm_sext),  64'hFFFF_FFFC);
    chk("lw_zext",    64'(imm_zext),  64'h0000_FFFC);
    chk("lw_lui",     64'(imm_lui),   64'hFFFC_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lw_pop_count", 64'(count),     64'd0);
    chk("lw_pop_vld",   64'(out_valid), 64'd0);

    // ---- Jump decode ----
    push1(32'h0C000C10, 32'h3000_0008);
    chk("jal_op",  64'(op),          64'h03);
    chk("jal_idx", 64'(instr_index), 64'h0000C10);
    chk("jal_jt",  64'(jump_target), 64'h3000_3040);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // PC+4 wraps past 2^32, so the region bits become 0.
    push1(32'h0BFF_FFFF, 32'hFFFF_FFFC);
    chk("jwrap_jt", 64'(jump_target), 64'h0FFF_FFFC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("jwrap_empty", 64'(count), 64'd0);

    // ---- Fill to DEPTH ----
    for (int i = 0; i < DEPTH; i++) begin
      push1(wrap_instr(i), wrap_pc(i));
      q_instr.push_back(wrap_instr(i));
      q_pc.push_back(wrap_pc(i));
    end
    chk("full_count",    64'(count),    64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);

    // A fifth push is held off while full.
    in_valid = 1'b1;
    in_instr = wrap_instr(DEPTH);
    in_pc    = wrap_pc(DEPTH);
    tick();
    chk("held_count",  64'(count),  64'(DEPTH));
    chk("held_head",   64'(out_pc), 64'(wrap_pc(0)));

    // ---- Continuous push/pop across pointer wrap ----
    // in_ready only looks at occupancy, so the first cycle at full can only pop.
    k = DEPTH;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_instr = wrap_instr(k);
      in_pc    = wrap_pc(k);
      chk($sformatf("wrap_count_%0d", c), 64'(count),     64'(q_pc.size()));
      chk($sformatf("wrap_pc_%0d", c),    64'(out_pc),    64'(q_pc[0]));
      chk($sformatf("wrap_imm_%0d", c),   64'(immediate), 64'(q_instr[0][15:0]));
      m_push = (q_pc.size() != DEPTH);
      m_pop  = (q_pc.size() != 0);
      tick();
      if (m_pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (m_push) begin
        q_instr.push_back(wrap_instr(k));
        q_pc.push_back(wrap_pc(k));
        k++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("wrap_end_count", 64'(count),  64'(q_pc.size()));
    chk("wrap_end_head",  64'(out_pc), 64'(q_pc[0]));

    // Clear with a plain flush.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_plain", 64'(count), 64'd0);

    // ---- Flush with simultaneous push and pop ----
    for (int i = 0; i < 3; i++) push1(wrap_instr(20 + i), wrap_pc(20 + i));
    chk("pre_flush_count", 64'(count), 64'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hDEAD_BEEF;
    in_pc     = 32'h0000_0BAD;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_vld",   64'(out_valid), 64'd0);
    chk("flush_op",    64'(op),        64'd0);
    tick();
    chk("flush_stays_empty", 64'(count), 64'd0);
    push1(32'h1234_5678, 32'h0000_0040);
    chk("post_flush_pc",  64'(out_pc),    64'h40);
    chk("post_flush_op",  64'(op),        64'h04);
    chk("post_flush_rs",  64'(rs),        64'd17);
    chk("post_flush_imm", 64'(immediate), 64'h5678);

    // ---- Reset together with flush ----
    push1(32'h2400_0099, 32'h0000_0044);
    chk("pre_rst_count", 64'(count), 64'd2);
    reset_n = 1'b0;
    flush   = 1'b1;
    tick();
    reset_n = 1'b1;
    flush   = 1'b0;
    chk("rstflush_count", 64'(count),     64'd0);
    chk("rstflush_vld",   64'(out_valid), 64'd0);
    push1(32'h0109_5020, 32'h0000_2000);
    chk("r_pc",    64'(out_pc),   64'h2000);
    chk("r_op",    64'(op),       64'd0);
    chk("r_rs",    64'(rs),       64'd8);
    chk("r_rt",    64'(rt),       64'd9);
    chk("r_rd",    64'(rd),       64'd10);
    chk("r_shamt", 64'(shamt),    64'd0);
    chk("r_func",  64'(func),     64'h20);
    chk("r_sext",  64'(imm_sext), 64'h0000_5020);

    // Fill the rest after reset and drain: order must follow push order.
    for (int i = 1; i < DEPTH; i++) push1(wrap_instr(40 + i), wrap_pc(40 + i));
    chk("post_rst_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    chk("drain_0", 64'(out_pc), 64'h2000);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("drain_%0d", i), 64'(out_pc), 64'(wrap_pc(40 + i)));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
